// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared phase codes and sizing helpers for the CPU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        PH_FETCH   = 3'd0,
        PH_DECODE  = 3'd1,
        PH_EXECUTE = 3'd2,
        PH_STORE   = 3'd3,
        PH_MEMORY  = 3'd4,
        PH_HALT    = 3'd5
    } phase_t;

    // Codes 0-3 keep the encoding of the old 2-bit phase bus.
    localparam logic [2:0] C_FETCH   = 3'd0;
    localparam logic [2:0] C_DECODE  = 3'd1;
    localparam logic [2:0] C_EXECUTE = 3'd2;
    localparam logic [2:0] C_STORE   = 3'd3;
    localparam logic [2:0] C_MEMORY  = 3'd4;
    localparam logic [2:0] C_HALT    = 3'd5;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : wait_counter
// Description : Saturating latency counter shared by the FETCH and MEMORY waits.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_counter
    import cpu_pkg::*;
#(
    parameter int FETCH_LAT = 1,
    parameter int MEM_LAT   = 1,
    parameter int W         = cnt_width(FETCH_LAT, MEM_LAT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic sel_mem,
    output logic done
);

    localparam logic [W-1:0] C_FETCH_LIM = W'(FETCH_LAT - 1);
    localparam logic [W-1:0] C_MEM_LIM   = W'(MEM_LAT - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_lim;

    assign w_lim = sel_mem ? C_MEM_LIM : C_FETCH_LIM;
    assign done  = (r_cnt >= w_lim);

    // Saturates at the limit so a late ack is honoured on the very cycle it arrives.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (inc && !done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Multi-cycle instruction phase FSM with memory waits, stall,
//               halt and retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int FETCH_LAT = 1,
    parameter int MEM_LAT   = 1,
    parameter int RET_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             stall,
    input  logic             mem_ready,
    input  logic             need_mem,
    input  logic             halt_req,
    output logic [2:0]       phase,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    logic [2:0]       r_phase;
    logic             r_mem_flag;
    logic             r_boot;
    logic [RET_W-1:0] r_retired;

    logic [2:0] w_next;
    logic       w_advance;
    logic       w_illegal;
    logic       w_go;
    logic       w_change;
    logic       w_waiting;
    logic       w_done;
    logic       w_fetch_exit;

    assign w_advance    = enable & ~stall;
    assign w_illegal    = (r_phase > C_HALT);
    // HALT ignores every input; illegal codes recover to STORE unconditionally.
    assign w_go         = (w_advance & (r_phase != C_HALT)) | w_illegal;
    assign w_change     = w_go & (w_next != r_phase);
    assign w_waiting    = (r_phase == C_FETCH) | (r_phase == C_MEMORY);
    assign w_fetch_exit = (r_phase == C_FETCH) & w_done & mem_ready;

    wait_counter #(
        .FETCH_LAT (FETCH_LAT),
        .MEM_LAT   (MEM_LAT)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_change),
        .inc     (w_advance & w_waiting),
        .sel_mem (r_phase == C_MEMORY),
        .done    (w_done)
    );

    always_comb begin
        w_next = r_phase;
        case (r_phase)
            C_STORE:   w_next = C_FETCH;
            C_FETCH:   if (w_done && mem_ready) w_next = C_DECODE;
            C_DECODE:  w_next = halt_req ? C_HALT : C_EXECUTE;
            C_EXECUTE: w_next = r_mem_flag ? C_MEMORY : C_STORE;
            C_MEMORY:  if (w_done && mem_ready) w_next = C_STORE;
            C_HALT:    w_next = C_HALT;
            default:   w_next = C_STORE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= C_STORE;
            r_mem_flag <= 1'b0;
            r_boot     <= 1'b1;
            r_retired  <= '0;
        end else begin
            if (w_go) begin
                r_phase <= w_next;
            end
            if (w_advance && (r_phase == C_DECODE) && !halt_req) begin
                r_mem_flag <= need_mem;
            end
            // The STORE exit straight out of reset retires nothing.
            if (w_advance && (r_phase == C_STORE)) begin
                if (r_boot) begin
                    r_boot <= 1'b0;
                end else begin
                    r_retired <= r_retired + 1'b1;
                end
            end
        end
    end

    assign phase   = r_phase;
    assign ir_load = ~reset & w_advance & w_fetch_exit;
    assign pc_inc  = ~reset & w_advance & (r_phase == C_STORE);
    assign halted  = (r_phase == C_HALT);
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Directed self-checking bench; three parameterisations share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic reset, enable, stall, mem_ready, need_mem, halt_req;

    logic [2:0]  ph_d, ph_m, ph_f;
    logic        ir_d, ir_m, ir_f;
    logic        pc_d, pc_m, pc_f;
    logic        hl_d, hl_m, hl_f;
    logic [15:0] ret_d, ret_f;
    logic [3:0]  ret_m;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_sequencer u_def (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .mem_ready(mem_ready), .need_mem(need_mem), .halt_req(halt_req),
        .phase(ph_d), .ir_load(ir_d), .pc_inc(pc_d), .halted(hl_d), .retired(ret_d)
    );

    phase_sequencer #(.FETCH_LAT(1), .MEM_LAT(3), .RET_W(4)) u_mem (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .mem_ready(mem_ready), .need_mem(need_mem), .halt_req(halt_req),
        .phase(ph_m), .ir_load(ir_m), .pc_inc(pc_m), .halted(hl_m), .retired(ret_m)
    );

    phase_sequencer #(.FETCH_LAT(2), .MEM_LAT(1), .RET_W(16)) u_fet (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .mem_ready(mem_ready), .need_mem(need_mem), .halt_req(halt_req),
        .phase(ph_f), .ir_load(ir_f), .pc_inc(pc_f), .halted(hl_f), .retired(ret_f)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Two reset edges; the strobes are checked while reset is still asserted.
    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        stall     = 1'b0;
        mem_ready = 1'b1;
        need_mem  = 1'b0;
        halt_req  = 1'b0;
        next_cyc();
        mid();
        chk("rst phase", int'(ph_d), 3);
        chk("rst pc_inc", int'(pc_d), 0);
        chk("rst ir_load", int'(ir_d), 0);
        next_cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp2[9] = '{3, 0, 1, 2, 4, 4, 4, 3, 0};

        reset = 1'b1; enable = 1'b1; stall = 1'b0;
        mem_ready = 1'b1; need_mem = 1'b0; halt_req = 1'b0;

        // Plain 4-phase loop
        do_reset();
        mid();
        chk("t1 ph store", int'(ph_d), 3);
        chk("t1 pc_inc", int'(pc_d), 1);
        chk("t1 ir_load store", int'(ir_d), 0);
        chk("t1 ret boot", int'(ret_d), 0);
        chk("t1 halted", int'(hl_d), 0);
        next_cyc(); mid();
        chk("t1 ph fetch", int'(ph_d), 0);
        chk("t1 ir_load fetch", int'(ir_d), 1);
        chk("t1 pc_inc fetch", int'(pc_d), 0);
        chk("t1 ret after boot", int'(ret_d), 0);
        next_cyc(); mid();
        chk("t1 ph decode", int'(ph_d), 1);
        next_cyc(); mid();
        chk("t1 ph execute", int'(ph_d), 2);
        next_cyc(); mid();
        chk("t1 ph store2", int'(ph_d), 3);
        chk("t1 pc_inc2", int'(pc_d), 1);
        next_cyc(); mid();
        chk("t1 ph fetch2", int'(ph_d), 0);
        chk("t1 ret one", int'(ret_d), 1);

        // MEMORY phase with MEM_LAT=3
        do_reset();
        need_mem = 1'b1;
        for (int i = 0; i < 9; i++) begin
            mid();
            chk($sformatf("t2 ph[%0d]", i), int'(ph_m), exp2[i]);
            next_cyc();
        end

        // FETCH_LAT=2 with a late ack, then an early ack that must be ignored
        do_reset();
        mid();
        chk("t3 ph store", int'(ph_f), 3);
        next_cyc();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4);
            mid();
            chk($sformatf("t3 ph fetch[%0d]", i), int'(ph_f), 0);
            chk($sformatf("t3 ir_load[%0d]", i), int'(ir_f), (i == 4) ? 1 : 0);
            next_cyc();
        end
        mid();
        chk("t3 ph decode", int'(ph_f), 1);
        next_cyc(); next_cyc(); next_cyc();
        mid();
        chk("t3 early ack ph", int'(ph_f), 0);
        chk("t3 early ack ir_load", int'(ir_f), 0);
        next_cyc(); mid();
        chk("t3 lat ack ir_load", int'(ir_f), 1);
        next_cyc(); mid();
        chk("t3 ph decode2", int'(ph_f), 1);

        // Stall in EXECUTE, enable low in STORE
        do_reset();
        next_cyc(); next_cyc(); next_cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("t4 stall ph[%0d]", i), int'(ph_d), 2);
            chk($sformatf("t4 stall pc_inc[%0d]", i), int'(pc_d), 0);
            next_cyc();
        end
        stall = 1'b0;
        mid();
        chk("t4 ph exec release", int'(ph_d), 2);
        next_cyc();
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk($sformatf("t4 frz ph[%0d]", i), int'(ph_d), 3);
            chk($sformatf("t4 frz pc_inc[%0d]", i), int'(pc_d), 0);
            chk($sformatf("t4 frz ret[%0d]", i), int'(ret_d), 0);
            next_cyc();
        end
        enable = 1'b1;
        mid();
        chk("t4 pc_inc resume", int'(pc_d), 1);
        next_cyc(); mid();
        chk("t4 ph fetch", int'(ph_d), 0);
        chk("t4 ret one", int'(ret_d), 1);

        // HALT is terminal until reset
        do_reset();
        next_cyc(); next_cyc(); next_cyc(); next_cyc(); next_cyc();
        mid();
        chk("t5 ph fetch", int'(ph_d), 0);
        chk("t5 ret one", int'(ret_d), 1);
        halt_req = 1'b1;
        next_cyc(); mid();
        chk("t5 ph decode", int'(ph_d), 1);
        next_cyc(); mid();
        chk("t5 ph halt", int'(ph_d), 5);
        chk("t5 halted", int'(hl_d), 1);
        for (int i = 0; i < 20; i++) begin
            enable    = i[0];
            stall     = i[1];
            mem_ready = i[2];
            need_mem  = i[3];
            halt_req  = i[4];
            next_cyc(); mid();
            chk($sformatf("t5 hold ph[%0d]", i), int'(ph_d), 5);
            chk($sformatf("t5 hold halted[%0d]", i), int'(hl_d), 1);
            chk($sformatf("t5 hold strobes[%0d]", i), int'({ir_d, pc_d}), 0);
        end
        do_reset();
        mid();
        chk("t5 post rst ph", int'(ph_d), 3);
        chk("t5 post rst ret", int'(ret_d), 0);
        chk("t5 post rst halted", int'(hl_d), 0);

        // RET_W=4 wrap after 16 counted instructions
        do_reset();
        next_cyc();
        for (int n = 1; n <= 17; n++) begin
            repeat (4) next_cyc();
            if (n >= 15) begin
                mid();
                chk($sformatf("t6 ret after %0d", n), int'(ret_m), n % 16);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
